// File: rtl/pclk_seq.sv
// Four-phase power-clock step-charger sequencer: warm-up ramp-in, continuous RUN, ordered DRAIN.
// Codes decode combinationally from registered state; each phase enters and leaves only at a ramp boundary.
module pclk_seq #(
   parameter int STEPS = 8,
   parameter int CW    = $clog2(STEPS + 1)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   output logic [4*CW-1:0] pos_code,
   output logic [4*CW-1:0] neg_code,
   output logic            active,
   output logic            sync
);

   localparam int            SW   = (STEPS > 1) ? $clog2(STEPS) : 1;
   localparam logic [SW-1:0] LAST = SW'(STEPS - 1);
   localparam logic [CW-1:0] FULL = CW'(STEPS);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t          state;
   logic [SW-1:0]   step;
   logic [1:0]      quad;
   logic [3:0]      live;
   logic [3:0]      live_eff;
   logic [3:0]      live_nxt;
   logic [1:0]      seg [4];
   logic [CW-1:0]   raw [4];
   logic [CW-1:0]   pos [4];

   // A phase becomes live on the very cycle its up-ramp begins, so its first code is 1, not 0.
   // Clearing at the end of every down segment is harmless in RUN because the next up-ramp re-arms it.
   always_comb begin
      live_eff = live;
      live_nxt = live;
      pos_code = '0;
      neg_code = '0;
      for (int k = 0; k < 4; k++) begin
         seg[k] = quad - 2'(k);
         raw[k] = '0;
         pos[k] = '0;
         if (state == RUN && quad == 2'(k) && step == '0)
            live_eff[k] = 1'b1;
         case (seg[k])
            2'd0:    raw[k] = CW'(step) + CW'(1);
            2'd1:    raw[k] = FULL;
            2'd2:    raw[k] = CW'(LAST - step);
            default: raw[k] = '0;
         endcase
         live_nxt[k] = live_eff[k] & ~(seg[k] == 2'd2 && step == LAST);
         pos[k] = live_eff[k] ? raw[k] : '0;
         pos_code[k*CW +: CW] = pos[k];
         neg_code[k*CW +: CW] = FULL - pos[k];
      end
   end

   assign active = (state != IDLE);
   assign sync   = (state == RUN) && (quad == 2'd0) && (step == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         step  <= '0;
         quad  <= '0;
         live  <= '0;
      end else begin
         case (state)
            IDLE: begin
               step <= '0;
               quad <= '0;
               live <= '0;
               if (en)
                  state <= RUN;
            end
            RUN, DRAIN: begin
               live <= live_nxt;
               if (step == LAST) begin
                  step <= '0;
                  quad <= quad + 2'd1;
                  if (state == RUN && quad == 2'd3 && !en)
                     state <= DRAIN;
                  if (state == DRAIN && quad == 2'd1) begin
                     state <= IDLE;
                     quad  <= '0;
                     live  <= '0;
                  end
               end else begin
                  step <= step + SW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pclk_seq.sv
// Bench for pclk_seq: STEPS=4 and STEPS=2 instances against a period-position waveform model.
module tb_pclk_seq;

   localparam int CW4 = 3;
   localparam int CW2 = 2;

   logic clk = 1'b0;
   logic clk_run = 1'b0;
   logic rst = 1'b0;
   logic en4 = 1'b0;
   logic en2 = 1'b0;
   logic [4*CW4-1:0] pos4, neg4;
   logic [4*CW2-1:0] pos2, neg2;
   logic act4, act2, sync4, sync2;

   int checks = 0;
   int errors = 0;

   // model: 0 idle, 1 run, 2 drain; mt = cycle position inside the current period/drain
   int mst [2];
   int mt [2];
   bit mfirst [2];
   int sv [2];

   pclk_seq #(.STEPS(4)) u4 (.clk(clk), .rst(rst), .en(en4), .pos_code(pos4),
                             .neg_code(neg4), .active(act4), .sync(sync4));
   pclk_seq #(.STEPS(2)) u2 (.clk(clk), .rst(rst), .en(en2), .pos_code(pos2),
                             .neg_code(neg2), .active(act2), .sync(sync2));

   always #5 clk = clk_run ? ~clk : clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
      end
   endtask

   function automatic int wave(input int s, input int p);
      if (p < s)           return p + 1;
      else if (p < 2*s)    return s;
      else if (p < 3*s)    return 3*s - 1 - p;
      else                 return 0;
   endfunction

   function automatic int mpos(input int id, input int k);
      int s;
      s = sv[id];
      if (mst[id] == 1) begin
         if (mfirst[id] && mt[id] < k*s) return 0;
         return wave(s, (mt[id] - k*s + 4*s) % (4*s));
      end else if (mst[id] == 2) begin
         if (k < 2) return 0;
         return wave(s, (mt[id] + 4*s - k*s) % (4*s));
      end
      return 0;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         mst[i] = 0; mt[i] = 0; mfirst[i] = 1'b0;
      end
   endtask

   task automatic model_step(input int id, input logic e);
      int s;
      s = sv[id];
      case (mst[id])
         0: if (e) begin mst[id] = 1; mt[id] = 0; mfirst[id] = 1'b1; end
         1: if (mt[id] == 4*s - 1) begin
               mt[id] = 0;
               mfirst[id] = 1'b0;
               if (!e) mst[id] = 2;
            end else mt[id]++;
         default: if (mt[id] == 2*s - 1) begin mst[id] = 0; mt[id] = 0; end
                  else mt[id]++;
      endcase
   endtask

   task automatic check_model();
      for (int k = 0; k < 4; k++) begin
         chk("u4_pos", 32'(pos4[k*CW4 +: CW4]), 32'(mpos(0, k)));
         chk("u4_neg", 32'(neg4[k*CW4 +: CW4]), 32'(4 - mpos(0, k)));
         chk("u2_pos", 32'(pos2[k*CW2 +: CW2]), 32'(mpos(1, k)));
         chk("u2_neg", 32'(neg2[k*CW2 +: CW2]), 32'(2 - mpos(1, k)));
      end
      chk("u4_active", 32'(act4), 32'(mst[0] != 0));
      chk("u2_active", 32'(act2), 32'(mst[1] != 0));
      chk("u4_sync", 32'(sync4), 32'(mst[0] == 1 && mt[0] == 0));
      chk("u2_sync", 32'(sync2), 32'(mst[1] == 1 && mt[1] == 0));
   endtask

   task automatic tick();
      @(posedge clk);
      model_step(0, en4);
      model_step(1, en2);
      @(negedge clk);
      check_model();
   endtask

   function automatic int p4(input int k);
      return int'(pos4[k*CW4 +: CW4]);
   endfunction

   typedef struct {
      logic en;
      int   p [4];
      logic sy;
   } vec_t;

   vec_t tbl [16];
   int e0 [16] = '{1,2,3,4,4,4,4,4,3,2,1,0,0,0,0,0};
   int e1 [16] = '{0,0,0,0,1,2,3,4,4,4,4,4,3,2,1,0};
   int e2 [16] = '{0,0,0,0,0,0,0,0,1,2,3,4,4,4,4,4};
   int e3 [16] = '{0,0,0,0,0,0,0,0,0,0,0,0,1,2,3,4};

   initial begin
      sv[0] = 4;
      sv[1] = 2;
      model_reset();
      for (int i = 0; i < 16; i++) begin
         tbl[i].en   = 1'b1;
         tbl[i].p[0] = e0[i];
         tbl[i].p[1] = e1[i];
         tbl[i].p[2] = e2[i];
         tbl[i].p[3] = e3[i];
         tbl[i].sy   = (i == 0);
      end

      // reset pulse with the clock stopped
      #2 rst = 1'b1;
      #1;
      chk("rst_pos4", 32'(pos4), 32'd0);
      for (int k = 0; k < 4; k++) begin
         chk("rst_neg4", 32'(neg4[k*CW4 +: CW4]), 32'd4);
         chk("rst_neg2", 32'(neg2[k*CW2 +: CW2]), 32'd2);
      end
      chk("rst_active", 32'(act4), 32'd0);
      chk("rst_sync", 32'(sync4), 32'd0);
      #1 rst = 1'b0;
      clk_run = 1'b1;
      @(negedge clk);
      tick();
      chk("idle_no_en", 32'(act4), 32'd0);

      // start: table-driven first period
      for (int i = 0; i < 16; i++) begin
         en4 = tbl[i].en;
         tick();
         for (int k = 0; k < 4; k++)
            chk($sformatf("start_p%0d_c%0d", k, i), 32'(p4(k)), 32'(tbl[i].p[k]));
         chk($sformatf("start_sync_c%0d", i), 32'(sync4), 32'(tbl[i].sy));
      end

      // stop: en drops in quad 1 of period 2, period completes, then 8-cycle drain
      for (int i = 0; i < 5; i++) tick();
      en4 = 1'b0;
      for (int i = 0; i < 11; i++) tick();
      chk("stop_period_end_active", 32'(act4), 32'd1);
      for (int d = 0; d < 8; d++) begin
         tick();
         chk("drain_p0", 32'(p4(0)), 32'd0);
         chk("drain_p1", 32'(p4(1)), 32'd0);
         chk("drain_p2", 32'(p4(2)), 32'(d < 4 ? 3 - d : 0));
         chk("drain_p3", 32'(p4(3)), 32'(d < 4 ? 4 : 7 - d));
         chk("drain_active", 32'(act4), 32'd1);
      end
      tick();
      chk("after_drain_active", 32'(act4), 32'd0);

      // re-enable during drain is ignored; one IDLE cycle then RUN
      en4 = 1'b1;
      tick();
      chk("restart_sync", 32'(sync4), 32'd1);
      en4 = 1'b0;
      for (int i = 0; i < 15; i++) tick();
      for (int d = 0; d < 8; d++) begin
         tick();
         if (d == 1) en4 = 1'b1;
         chk("reen_drain_active", 32'(act4), 32'd1);
         chk("reen_drain_sync", 32'(sync4), 32'd0);
      end
      tick();
      chk("reen_idle_active", 32'(act4), 32'd0);
      tick();
      chk("reen_run_sync", 32'(sync4), 32'd1);
      chk("reen_run_active", 32'(act4), 32'd1);

      // reset at quad 2 step 1, mid-cycle
      for (int i = 0; i < 9; i++) tick();
      chk("pre_rst_p0", 32'(p4(0)), 32'd2);
      #2 rst = 1'b1;
      #1;
      chk("midrst_pos4", 32'(pos4), 32'd0);
      for (int k = 0; k < 4; k++)
         chk("midrst_neg4", 32'(neg4[k*CW4 +: CW4]), 32'd4);
      chk("midrst_active", 32'(act4), 32'd0);
      chk("midrst_sync", 32'(sync4), 32'd0);
      model_reset();
      en4 = 1'b0;
      #1 rst = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      chk("post_rst_idle", 32'(act4), 32'd0);

      // STEPS=2: three periods of 8 cycles
      en2 = 1'b1;
      for (int i = 0; i < 24; i++) begin
         tick();
         chk("s2_sync", 32'(sync2), 32'(i % 8 == 0));
         for (int k = 0; k < 4; k++)
            chk("s2_sum", 32'(pos2[k*CW2 +: CW2]) + 32'(neg2[k*CW2 +: CW2]), 32'd2);
      end

      // randomized en on both instances
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 15) == 0) en4 = ~en4;
         if ($urandom_range(0, 11) == 0) en2 = ~en2;
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pclk_seq.md
PCLK_SEQ -- requirements
Module: pclk_seq

Interface
REQ-001 Parameter: STEPS, default 8, number of charge steps per ramp, legal 2..64.
REQ-002 Parameter: CW, default $clog2(STEPS+1), width of one step code.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 en  input  1  run request; level-sensitive, sampled each clk.
REQ-006 pos_code  output  4*CW  step-charger code for power-clock phase k in bits [k*CW +: CW], k=0..3; drives clkpos rails.
REQ-007 neg_code  output  4*CW  complementary code per phase, same slicing; drives clkneg rails.
REQ-008 active  output  1  high whenever the sequencer is not in IDLE.
REQ-009 sync  output  1  one-cycle pulse at the start of each RUN period.

Function
REQ-010 The block SHALL implement states IDLE, RUN and DRAIN, plus a step counter step (0..STEPS-1), a quadrant counter quad (0..3) and a per-phase live[3:0] mask.
REQ-011 In RUN and DRAIN, step SHALL increment each cycle; at STEPS-1 it SHALL wrap to 0 and quad SHALL increment mod 4.
REQ-012 Segment of phase k SHALL be seg=(quad-k) mod 4: 0=up, 1=hold, 2=down, 3=off.
REQ-013 Raw code per segment SHALL be: up -> step+1; hold -> STEPS; down -> STEPS-1-step; off -> 0.
REQ-014 pos_code[k] SHALL equal the raw code when live[k]=1, else 0; neg_code[k] SHALL always equal STEPS-pos_code[k].
REQ-015 Outputs SHALL be decoded from current registered state, with no added latency.
REQ-016 IDLE: step=0, quad=0, live=0; if en=1, next state RUN.
REQ-017 RUN: live[k] SHALL set on the cycle where quad==k and step==0, giving a zero-start warm-up with no mid-ramp entry.
REQ-018 RUN: at period end (quad==3, step==STEPS-1), if en=0 next state DRAIN, else RUN continues; en changes mid-period SHALL NOT truncate the period.
REQ-019 DRAIN: live bits SHALL NOT set; live[k] SHALL clear on the last cycle of its down segment (seg==2, step==STEPS-1).
REQ-020 DRAIN SHALL last exactly 2*STEPS cycles (quad 0..1), then go to IDLE with all live=0.
REQ-021 en during DRAIN SHALL be ignored; restart is possible only from IDLE.
REQ-022 sync SHALL be 1 iff state==RUN, quad==0 and step==0.
REQ-023 active SHALL be 1 iff state!=IDLE.

Reset
REQ-024 While rst=1, the block SHALL force state=IDLE, step=0, quad=0, live=0, pos_code=0, neg_code=STEPS in every slice, active=0 and sync=0, independent of clk.
REQ-025 Reset asserted mid-RUN or mid-DRAIN SHALL take effect immediately, with no drain sequence.
REQ-026 After rst deasserts, the first RUN SHALL start only on a clk edge with en=1.

Verification
REQ-027 Reset: STEPS=4, rst pulse with clk stopped -> pos_code=0, all neg slices=4, active=0, sync=0.
REQ-028 Start: STEPS=4, en=1 from IDLE:
- sync=1 on the first RUN cycle.
- phase0 pos over 16 cycles: 1,2,3,4,4,4,4,4,3,2,1,0,0,0,0,0.
- phase1 = 0 for 4 cycles, then 1,2,3,4...
- phase3 = 0 for 12 cycles.
REQ-029 Stop: STEPS=4, en drops in quad 1 of period 2:
- period 2 completes.
- DRAIN lasts 8 cycles.
- phase2 sequence 3,2,1,0 then phase3 4,4,4,4,3,2,1,0.
- phase0/1 stay 0.
- active falls after the 8th DRAIN cycle.
REQ-030 Reenable in DRAIN: en=1 in the 3rd DRAIN cycle -> DRAIN still completes, one IDLE cycle follows, then RUN with sync=1.
REQ-031 Reset mid-run: rst at quad 2, step 1 -> same-cycle outputs at reset values; no ramp-down observed.
REQ-032 Boundary: STEPS=2, en held high for 3 periods -> period = 8 cycles, sync every 8 cycles, neg_code+pos_code=2 in every slice every cycle.
